// File: rtl/uart_tx_frame_controller.sv
// UART transmit frame sequencer with oversample tick generator and run-time config; `UART_TX_BREAK_EN adds break generation.
// Latency: start bit appears the cycle after the txValid/txReady handshake; frameDone marks the last stop-bit cycle.
// Backpressure: txReady is high only in IDLE, holding off the next word until the frame ends (min 1 clk idle gap).
module uart_tx_frame_controller #(
    parameter int                       DATA_WIDTH      = 8,
    parameter int                       DIVISOR_WIDTH   = 16,
    parameter logic [DIVISOR_WIDTH-1:0] DEFAULT_DIVISOR = 16'd326
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfgLoad,
    input  logic [DIVISOR_WIDTH-1:0] cfgDivisor,
    input  logic [4:0]               cfgOverSampling,
    input  logic [3:0]               cfgDataBits,
    input  logic                     cfgParityEnable,
    input  logic                     cfgParityType,
    input  logic [1:0]               cfgStopBits,
    input  logic [DATA_WIDTH-1:0]    txData,
    input  logic                     txValid,
`ifdef UART_TX_BREAK_EN
    input  logic                     breakReq,
`endif
    output logic                     txReady,
    output logic                     tx,
    output logic                     busy,
    output logic                     frameDone,
    output logic                     cfgError
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK, MAB} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

    state_t                   state_q, state_d;
    logic [DIVISOR_WIDTH-1:0] divisor_q, tick_q;
    logic [4:0]               os_q, samp_q;
    logic [3:0]               data_bits_q, bit_idx_q;
    logic                     par_en_q, par_type_q;
    logic [1:0]               stop_q;
    logic                     stop_cnt_q;
    logic [DATA_WIDTH-1:0]    data_q, data_mask;
    logic                     rdy_en_q, cfg_error_q;
    logic                     brk_req, hs, os_tick, bit_end, last_data, last_stop, counting;
    logic                     cfg_ok, cfg_accept, tx_bit, frame_done;

`ifdef UART_TX_BREAK_EN
    assign brk_req  = breakReq;
    assign counting = (state_q != IDLE) && (state_q != BRK);
`else
    assign brk_req  = 1'b0;
    assign counting = (state_q != IDLE);
`endif

    // rdy_en_q keeps txReady low while reset is asserted even though the FSM sits in IDLE
    assign txReady   = (state_q == IDLE) && rdy_en_q && !brk_req;
    assign hs        = txValid && txReady;
    assign busy      = (state_q != IDLE);
    assign tx        = tx_bit;
    assign frameDone = frame_done;
    assign cfgError  = cfg_error_q;

    assign os_tick   = (tick_q == divisor_q - DIVISOR_WIDTH'(1));
    assign bit_end   = os_tick && (samp_q == os_q - 5'd1);
    assign last_data = (bit_idx_q == data_bits_q - 4'd1);
    assign last_stop = (stop_q == 2'd1) || stop_cnt_q;

    assign cfg_ok = (cfgDivisor != '0)
                 && ((cfgOverSampling == 5'd13) || (cfgOverSampling == 5'd16))
                 && (cfgDataBits >= 4'd5) && (cfgDataBits <= 4'd8)
                 && ((cfgStopBits == 2'd1) || (cfgStopBits == 2'd2));
    assign cfg_accept = cfgLoad && (state_q == IDLE) && !hs && !brk_req && cfg_ok;

    // Unused high data bits are zeroed at capture so parity is a plain reduction XOR
    always_comb begin
        data_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            data_mask[i] = (i < int'(data_bits_q));
    end

    always_comb begin
        state_d    = state_q;
        tx_bit     = 1'b1;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs)
                    state_d = START;
`ifdef UART_TX_BREAK_EN
                else if (breakReq && rdy_en_q)
                    state_d = BRK;
`endif
            end
            START: begin
                tx_bit = 1'b0;
                if (bit_end)
                    state_d = DATA;
            end
            DATA: begin
                tx_bit = data_q[bit_idx_q[IDX_W-1:0]];
                if (bit_end && last_data)
                    state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                tx_bit = (^data_q) ^ par_type_q;
                if (bit_end)
                    state_d = STOP;
            end
            STOP: begin
                if (bit_end && last_stop) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
`ifdef UART_TX_BREAK_EN
            BRK: begin
                tx_bit = 1'b0;
                if (!breakReq)
                    state_d = MAB;
            end
            MAB: begin
                if (bit_end)
                    state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q     <= '0;
            samp_q     <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (hs || !counting) begin
                tick_q <= '0;
                samp_q <= '0;
            end else begin
                tick_q <= os_tick ? '0 : tick_q + DIVISOR_WIDTH'(1);
                if (bit_end)
                    samp_q <= '0;
                else if (os_tick)
                    samp_q <= samp_q + 5'd1;
            end
            if (hs) begin
                data_q     <= txData & data_mask;
                bit_idx_q  <= '0;
                stop_cnt_q <= 1'b0;
            end else if (bit_end) begin
                if (state_q == DATA)
                    bit_idx_q <= last_data ? '0 : bit_idx_q + 4'd1;
                if (state_q == STOP)
                    stop_cnt_q <= !last_stop;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divisor_q   <= DEFAULT_DIVISOR;
            os_q        <= 5'd16;
            data_bits_q <= 4'd8;
            par_en_q    <= 1'b1;
            par_type_q  <= 1'b0;
            stop_q      <= 2'd1;
            cfg_error_q <= 1'b0;
        end else begin
            cfg_error_q <= cfgLoad && !cfg_accept;
            if (cfg_accept) begin
                divisor_q   <= cfgDivisor;
                os_q        <= cfgOverSampling;
                data_bits_q <= cfgDataBits;
                par_en_q    <= cfgParityEnable;
                par_type_q  <= cfgParityType;
                stop_q      <= cfgStopBits;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_controller.sv
// Scoreboarded bench for uart_tx_frame_controller: stimulus pushes expected frames and cfgError outcomes,
// independent monitors watch tx/frameDone/cfgError and compare against them.
`timescale 1ns/1ps
module tb_uart_tx_frame_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfgLoad = 1'b0;
    logic [15:0] cfgDivisor = '0;
    logic [4:0]  cfgOverSampling = '0;
    logic [3:0]  cfgDataBits = '0;
    logic        cfgParityEnable = 1'b0;
    logic        cfgParityType = 1'b0;
    logic [1:0]  cfgStopBits = '0;
    logic [7:0]  txData = '0;
    logic        txValid = 1'b0;
    logic        txReady, tx, busy, frameDone, cfgError;

    uart_tx_frame_controller dut (
        .clk(clk), .reset(reset), .cfgLoad(cfgLoad), .cfgDivisor(cfgDivisor),
        .cfgOverSampling(cfgOverSampling), .cfgDataBits(cfgDataBits),
        .cfgParityEnable(cfgParityEnable), .cfgParityType(cfgParityType),
        .cfgStopBits(cfgStopBits), .txData(txData), .txValid(txValid),
        .txReady(txReady), .tx(tx), .busy(busy), .frameDone(frameDone), .cfgError(cfgError)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          period;
        int          gap;
        bit          abort_exp;
    } exp_t;

    exp_t exp_q[$];
    bit   cfg_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_active = 1'b0;
    int   last_done_cyc = -1000;

    int m_div, m_os, m_db, m_stop;
    bit m_par, m_odd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_div = 326; m_os = 16; m_db = 8; m_par = 1'b1; m_odd = 1'b0; m_stop = 1;
    endtask

    // Frame as a list of line levels, one per bit period, LSB-first data
    function automatic exp_t model_frame(input logic [7:0] d, input int gap, input bit ab);
        exp_t e;
        int   n;
        int   ones;
        e.bits = '1;
        ones = 0;
        e.bits[0] = 1'b0;
        for (int i = 0; i < m_db; i++) begin
            e.bits[1 + i] = d[i];
            ones += int'(d[i]);
        end
        n = 1 + m_db;
        if (m_par) begin
            e.bits[n] = ((ones % 2) == 1) ^ m_odd;
            n++;
        end
        e.nbits     = n + m_stop;
        e.period    = m_div * m_os;
        e.gap       = gap;
        e.abort_exp = ab;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input int div, input int os, input int db, input int pe,
                          input int pt, input int st, input bit in_frame);
        bit ok;
        ok = !in_frame && (div != 0) && (os == 13 || os == 16) && (db >= 5 && db <= 8)
             && (st == 1 || st == 2);
        cfgDivisor      = 16'(div);
        cfgOverSampling = 5'(os);
        cfgDataBits     = 4'(db);
        cfgParityEnable = pe[0];
        cfgParityType   = pt[0];
        cfgStopBits     = 2'(st);
        cfg_q.push_back(!ok);
        cfgLoad = 1'b1;
        tick();
        cfgLoad = 1'b0;
        if (ok) begin
            m_div = div; m_os = os; m_db = db; m_par = pe[0]; m_odd = pt[0]; m_stop = st;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int gap, input bit ab,
                              input bit keep, input bit collide);
        int n;
        txData  = d;
        txValid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!txReady && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("accept_handshake", txReady, 1);
        if (!txReady) begin
            txValid = 1'b0;
            tick();
            return;
        end
        if (collide) begin
            cfgDivisor = 16'd3; cfgOverSampling = 5'd13; cfgDataBits = 4'd7;
            cfgParityEnable = 1'b0; cfgParityType = 1'b1; cfgStopBits = 2'd2;
            cfgLoad = 1'b1;
            cfg_q.push_back(1'b1);
        end
        exp_q.push_back(model_frame(d, gap, ab));
        tick();
        cfgLoad = 1'b0;
        if (!keep) txValid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < 20000) begin
            tick();
            n++;
        end
        check("drain_timeout", (exp_q.size() == 0 && !mon_active), 1);
    endtask

    initial begin : frame_mon
        exp_t e;
        int   total, bad, done_at, start_cyc;
        bit   aborted, prev_tx;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_tx = 1'b1;
            end else begin
                if (frameDone === 1'b1) check("spurious_frameDone", frameDone, 0);
                if (prev_tx && tx === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_start", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        mon_active = 1'b1;
                        total = e.nbits * e.period;
                        bad = 0; done_at = -1; aborted = 1'b0; start_cyc = cyc;
                        if (e.gap >= 0) check("b2b_gap", start_cyc - last_done_cyc, e.gap);
                        for (int c = 0; c < total; c++) begin
                            if (c > 0) @(negedge clk);
                            if (!reset) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (tx !== e.bits[c / e.period]) bad++;
                            if (busy !== 1'b1 || txReady !== 1'b0) bad++;
                            if (frameDone === 1'b1) begin
                                if (done_at < 0) done_at = c;
                                else bad++;
                            end
                        end
                        check("frame_wave", bad, 0);
                        check("frame_abort", aborted, e.abort_exp);
                        if (!aborted) begin
                            check("frameDone_pos", done_at, total - 1);
                            last_done_cyc = start_cyc + total - 1;
                            @(negedge clk);
                            check("ready_after_done", txReady, 1);
                            check("idle_after_done", busy, 0);
                        end
                        mon_active = 1'b0;
                    end
                end
                prev_tx = tx;
            end
        end
    end

    initial begin : cfg_mon
        bit ld;
        bit exp_err;
        forever begin
            @(posedge clk);
            ld = cfgLoad && reset;
            @(negedge clk);
            if (reset) begin
                if (ld) begin
                    if (cfg_q.size() == 0) begin
                        check("cfg_unexpected_load", 0, 1);
                    end else begin
                        exp_err = cfg_q.pop_front();
                        check("cfgError", cfgError, exp_err);
                    end
                end else if (cfgError === 1'b1) begin
                    check("spurious_cfgError", cfgError, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int div, os, db, pe, pt, st;
        logic [7:0] d, d2;
        bit b2b;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_txReady", txReady, 0);
        check("rst_busy", busy, 0);
        check("rst_frameDone", frameDone, 0);
        check("rst_cfgError", cfgError, 0);
        tick();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_release", txReady, 1);
        tick();

        // 8 bits even parity, 32 clk per bit
        do_cfg(2, 16, 8, 1, 0, 1, 1'b0);
        send_frame(8'hA5, -1, 1'b0, 1'b0, 1'b0);
        wait_drain();

        // 7 bits odd parity, 39 clk per bit
        do_cfg(3, 13, 7, 1, 1, 1, 1'b0);
        send_frame(8'h41, -1, 1'b0, 1'b0, 1'b0);
        wait_drain();

        // 5 bits, no parity, 2 stop bits; upper data bits must be ignored
        do_cfg(2, 16, 5, 0, 0, 2, 1'b0);
        send_frame(8'hFF, -1, 1'b0, 1'b0, 1'b0);
        wait_drain();

        // back-to-back with txValid held high
        do_cfg(2, 16, 8, 1, 0, 1, 1'b0);
        send_frame(8'h55, -1, 1'b0, 1'b1, 1'b0);
        send_frame(8'h0F, 2, 1'b0, 1'b0, 1'b0);
        wait_drain();

        // rejected configuration loads keep the previous setup
        send_frame(8'h3C, -1, 1'b0, 1'b0, 1'b0);
        repeat (40) tick();
        do_cfg(2, 13, 8, 1, 0, 1, 1'b1);
        wait_drain();
        do_cfg(2, 16, 9, 1, 0, 1, 1'b0);
        do_cfg(0, 16, 8, 1, 0, 1, 1'b0);
        do_cfg(2, 15, 8, 1, 0, 1, 1'b0);
        do_cfg(2, 16, 8, 1, 0, 3, 1'b0);
        do_cfg(2, 16, 4, 1, 0, 1, 1'b0);
        send_frame(8'hC3, -1, 1'b0, 1'b0, 1'b0);
        wait_drain();
        send_frame(8'h99, -1, 1'b0, 1'b0, 1'b1);
        wait_drain();

        // randomized configurations and data
        for (int k = 0; k < 25; k++) begin
            div = $urandom_range(1, 3);
            os  = ($urandom_range(0, 1) == 1) ? 16 : 13;
            db  = $urandom_range(5, 8);
            pe  = $urandom_range(0, 1);
            pt  = $urandom_range(0, 1);
            st  = $urandom_range(1, 2);
            do_cfg(div, os, db, pe, pt, st, 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       do_cfg(0, os, db, pe, pt, st, 1'b0);
                    1:       do_cfg(div, 15, db, pe, pt, st, 1'b0);
                    2:       do_cfg(div, os, $urandom_range(9, 15), pe, pt, st, 1'b0);
                    default: do_cfg(div, os, db, pe, pt, 3 * $urandom_range(0, 1), 1'b0);
                endcase
            end
            d   = 8'($urandom);
            d2  = 8'($urandom);
            b2b = ($urandom_range(0, 3) == 0);
            send_frame(d, -1, 1'b0, b2b, 1'b0);
            if (b2b) send_frame(d2, 2, 1'b0, 1'b0, 1'b0);
            wait_drain();
        end

        // reset in the middle of data bit 3 aborts the frame
        do_cfg(2, 16, 8, 1, 0, 1, 1'b0);
        send_frame(8'hB6, -1, 1'b1, 1'b0, 1'b0);
        repeat (4 * 32 + 16) tick();
        reset = 1'b0;
        @(negedge clk);
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_frameDone", frameDone, 0);
        check("abort_txReady", txReady, 0);
        repeat (3) tick();
        reset = 1'b1;
        model_reset();
        tick();
        do_cfg(2, 16, 8, 1, 0, 1, 1'b0);
        send_frame(8'h6D, -1, 1'b0, 1'b0, 1'b0);
        wait_drain();

        repeat (3) tick();
        check("cfg_queue_empty", cfg_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_controller.md
Name: uart_tx_frame_controller

Overview:
- Sequences one UART transmit frame per accepted word: start bit, 5–8 data bits LSB first, optional even/odd parity, 1 or 2 stop bits.
- Contains its own oversample tick generator and a run-time configuration register (oversampling, data bits, parity, stop bits).
- Sits between the transmit-side data source (valid/ready) and the serial tx pin; the configuration port is driven by the config agent or register block.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame; txData width.
DIVISOR_WIDTH, 16, width of the clocks-per-oversample-tick divisor.
DEFAULT_DIVISOR, 16'd326, divisor loaded at reset (9600 baud × 16 at 50 MHz).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
cfgLoad  input  1  one-cycle request to latch the cfg* inputs.
cfgDivisor  input  DIVISOR_WIDTH  clk cycles per oversample tick.
cfgOverSampling  input  5  oversample ticks per bit; 16 or 13 only.
cfgDataBits  input  4  data bits per frame; 5..8 only.
cfgParityEnable  input  1  1 = parity bit present.
cfgParityType  input  1  0 = even, 1 = odd.
cfgStopBits  input  2  1 or 2 only.
txData  input  DATA_WIDTH  word to send; low cfgDataBits bits used.
txValid  input  1  source has a word.
txReady  output  1  controller accepts a word this cycle.
tx  output  1  serial line.
busy  output  1  frame in progress.
frameDone  output  1  one-cycle pulse at end of last stop bit.
cfgError  output  1  one-cycle pulse when cfgLoad is rejected.

Behaviour:
- Reset (async assert, sync release) sets the following values.
  - Outputs: tx=1, txReady=0 during reset, busy=0, frameDone=0, cfgError=0, FSM=IDLE, counters=0.
  - Configuration: divisor=DEFAULT_DIVISOR, oversampling=16, data bits=8, parity enabled and even, stop bits=1.
  - txReady=1 from the first clock after release.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, txReady=1, busy=0. On txValid&&txReady, latch txData and move to START; tx=0 on the next cycle.
- Timing: a tick counter counts 0..divisor-1, giving osTick on the terminal count. A sample counter counts osTicks 0..OS-1, giving bitEnd.
  - One bit period = divisor × OS clk cycles exactly.
  - Both counters are cleared on frame accept.
- START: tx=0 for one bit period, then go to DATA.
- DATA: tx=data[bitIdx], bitIdx 0..cfgDataBits-1. After the last data bit, go to PARITY if parity is enabled, else STOP.
- PARITY: tx = XOR of the used data bits, XORed with cfgParityType. One bit period.
- STOP: tx=1 for cfgStopBits bit periods.
  - At the final bitEnd: frameDone=1 for one cycle and the FSM returns to IDLE in the same cycle.
  - txReady=1 on the following cycle.
  - Back-to-back frames therefore have a minimum idle gap of 1 clk.
- busy=1 and txReady=0 in every state except IDLE.
- Frame length in bits = 1 + dataBits + parityEnable + stopBits.
- Configuration load:
  - cfgLoad is honoured only in IDLE with no txValid handshake in the same cycle; the frame handshake wins.
  - cfgLoad while busy or during a handshake: ignored, cfgError pulses, previous configuration kept.
  - Invalid values are rejected the same way with cfgError, all fields unchanged: divisor=0, OS∉{13,16}, dataBits∉5..8, stopBits∉{1,2}.
  - Configuration is never changed mid-frame.
- txData bits above cfgDataBits are ignored.
- A reset mid-frame aborts immediately: tx=1, and no frameDone pulse.

Optional Feature:
UART_TX_BREAK_EN
- With the macro defined: adds input breakReq (1 bit).
  - In IDLE with breakReq=1: tx=0, txReady=0, busy=1, no frame is accepted.
  - On breakReq deassertion: tx=1 for one full bit period (mark-after-break), then IDLE.
  - breakReq asserted mid-frame is ignored until the frame completes.
- Without the macro: no breakReq port; tx is low only during start, data-0 or parity-0 bits.

Test Plan:
- Default cfg, divisor 2, OS 16, 8 bits, even parity, 1 stop; send 0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,0,1; each bit 32 clk; frameDone 352 clk after accept; txReady=1 next cycle.
- cfg 7 bits, odd parity, divisor 3, OS 13; send 0x41 → bits 0,1000001,1,1; each bit 39 clk; parity=1.
- cfg 5 bits, no parity, 2 stop; send 0xFF → 0,11111,1,1; 8 bit periods; bits 7:5 ignored.
- txValid held high with 0x55 then 0x0F → two frames, exactly 1 idle clk between frameDone and the next start bit.
- cfgLoad mid-frame with OS=13, and cfgLoad in IDLE with dataBits=9 → cfgError pulse each time; subsequent frame still uses the previous timing and width.
- Assert reset during DATA bit 3 → tx=1, busy=0, no frameDone; after release the next frame is sent cleanly from its start bit.
